// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RISC-V control sequencer: opcodes,
// ALU operation codes, mux selects and the state enumeration.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [2:0] ALU_OP_R = 3'b000;
  localparam logic [2:0] ALU_OP_I = 3'b001;
  localparam logic [2:0] ALU_OP_U = 3'b010;
  localparam logic [2:0] ALU_OP_S = 3'b011;
  localparam logic [2:0] ALU_OP_B = 3'b100;
  localparam logic [2:0] ALU_OP_J = 3'b101;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_U   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath/memory (slave).
interface multicycle_control_fsm_if;
  import riscv_ctrl_pkg::*;

  logic [6:0] OP_i;
  logic       Mem_Ready_i;
  logic       Mem_Read_o;
  logic       Mem_Write_o;
  logic       I_or_D_o;
  logic       IR_Write_o;
  logic       PC_Write_o;
  logic       Branch_o;
  logic       PC_Src_o;
  logic [1:0] ALU_Src_A_o;
  logic [1:0] ALU_Src_B_o;
  logic [2:0] ALU_Op_o;
  logic [1:0] Mem_to_Reg_o;
  logic       Reg_Write_o;
  logic       Instr_Done_o;
  logic       Trap_o;

  modport master (
    input  OP_i, Mem_Ready_i,
    output Mem_Read_o, Mem_Write_o, I_or_D_o, IR_Write_o, PC_Write_o, Branch_o,
           PC_Src_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Mem_to_Reg_o,
           Reg_Write_o, Instr_Done_o, Trap_o
  );

  modport slave (
    output OP_i, Mem_Ready_i,
    input  Mem_Read_o, Mem_Write_o, I_or_D_o, IR_Write_o, PC_Write_o, Branch_o,
           PC_Src_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Mem_to_Reg_o,
           Reg_Write_o, Instr_Done_o, Trap_o
  );

endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle instruction sequencer with a shared, variable-latency memory port.
// state    | meaning
// FETCH    | read instruction at PC, wait for Mem_Ready_i
// DECODE   | ALUOut <= OldPC + imm, dispatch on opcode
// EXEC_*   | ALU operation for R / I / U formats
// ALU_WB   | write ALUOut to rd, retire
// MEM_ADDR | compute load/store address
// MEM_RD   | data read, wait for Mem_Ready_i
// MEM_WB   | write MDR to rd, retire
// MEM_WR   | data write, retire when accepted
// BRANCH   | conditional PC update from ALUOut, retire
// JAL/JALR | link and jump, retire
// TRAP     | illegal opcode or memory timeout, held until reset
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_wait;
  logic              timeout;
  logic              ready;

  assign ready    = bus.Mem_Ready_i;
  assign mem_wait = is_mem_state(state_q) && !ready;
  assign timeout  = (MEM_WAIT_MAX != 0) && mem_wait && (wait_q == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_wait && (wait_q != '1)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.Mem_Read_o   = 1'b0;
    bus.Mem_Write_o  = 1'b0;
    bus.I_or_D_o     = 1'b0;
    bus.IR_Write_o   = 1'b0;
    bus.PC_Write_o   = 1'b0;
    bus.Branch_o     = 1'b0;
    bus.PC_Src_o     = 1'b0;
    bus.ALU_Src_A_o  = SRC_A_PC;
    bus.ALU_Src_B_o  = SRC_B_RS2;
    bus.ALU_Op_o     = ALU_OP_I;
    bus.Mem_to_Reg_o = WB_ALUOUT;
    bus.Reg_Write_o  = 1'b0;
    bus.Instr_Done_o = 1'b0;
    bus.Trap_o       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        bus.Mem_Read_o  = 1'b1;
        bus.ALU_Src_B_o = SRC_B_FOUR;
        // An access abandoned by reset must not commit IR or PC
        bus.IR_Write_o  = ready && reset;
        bus.PC_Write_o  = ready && reset;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.ALU_Src_A_o = SRC_A_OLDPC;
        bus.ALU_Src_B_o = SRC_B_IMM;
        case (bus.OP_i)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_JALR:            state_d = S_JALR;
          OP_LUI:             state_d = S_EXEC_U;
          default:            state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        bus.ALU_Src_A_o = SRC_A_RS1;
        bus.ALU_Op_o    = ALU_OP_R;
        state_d         = S_ALU_WB;
      end
      S_EXEC_I: begin
        bus.ALU_Src_A_o = SRC_A_RS1;
        bus.ALU_Src_B_o = SRC_B_IMM;
        state_d         = S_ALU_WB;
      end
      S_EXEC_U: begin
        bus.ALU_Src_B_o = SRC_B_IMM;
        bus.ALU_Op_o    = ALU_OP_U;
        state_d         = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.Reg_Write_o  = 1'b1;
        bus.Instr_Done_o = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.ALU_Src_A_o = SRC_A_RS1;
        bus.ALU_Src_B_o = SRC_B_IMM;
        if (bus.OP_i == OP_STORE) begin
          bus.ALU_Op_o = ALU_OP_S;
          state_d      = S_MEM_WR;
        end else begin
          state_d      = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        bus.Mem_Read_o = 1'b1;
        bus.I_or_D_o   = 1'b1;
        if (ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.Reg_Write_o  = 1'b1;
        bus.Mem_to_Reg_o = WB_MDR;
        bus.Instr_Done_o = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_WR: begin
        bus.Mem_Write_o  = 1'b1;
        bus.I_or_D_o     = 1'b1;
        bus.Instr_Done_o = ready && reset;
        if (ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALU_Src_A_o  = SRC_A_RS1;
        bus.ALU_Op_o     = ALU_OP_B;
        bus.Branch_o     = 1'b1;
        bus.PC_Src_o     = 1'b1;
        bus.Instr_Done_o = 1'b1;
        state_d          = S_FETCH;
      end
      S_JAL: begin
        bus.PC_Write_o   = 1'b1;
        bus.PC_Src_o     = 1'b1;
        bus.Reg_Write_o  = 1'b1;
        bus.Mem_to_Reg_o = WB_PC;
        bus.ALU_Op_o     = ALU_OP_J;
        bus.Instr_Done_o = 1'b1;
        state_d          = S_FETCH;
      end
      S_JALR: begin
        bus.ALU_Src_A_o  = SRC_A_RS1;
        bus.ALU_Src_B_o  = SRC_B_IMM;
        bus.PC_Write_o   = 1'b1;
        bus.Reg_Write_o  = 1'b1;
        bus.Mem_to_Reg_o = WB_PC;
        bus.Instr_Done_o = 1'b1;
        state_d          = S_FETCH;
      end
      S_TRAP: begin
        bus.Trap_o = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    // A ready in the limit cycle has already advanced the state
    if (timeout) state_d = S_TRAP;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed cycle-by-cycle check of the sequencer outputs with a 3-cycle memory timeout.
module tb_multicycle_control_fsm;

  logic clk;
  logic reset;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(
    .MEM_WAIT_MAX(3),
    .WAIT_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {rd wr iod irw pcw br pcs} A B op m2r {rw done trap}
  logic [18:0] outs;
  assign outs = {bus.Mem_Read_o, bus.Mem_Write_o, bus.I_or_D_o, bus.IR_Write_o,
                 bus.PC_Write_o, bus.Branch_o, bus.PC_Src_o, bus.ALU_Src_A_o,
                 bus.ALU_Src_B_o, bus.ALU_Op_o, bus.Mem_to_Reg_o,
                 bus.Reg_Write_o, bus.Instr_Done_o, bus.Trap_o};

  localparam logic [18:0] E_FETCH_W = 19'b1000000_00_10_001_00_000;
  localparam logic [18:0] E_FETCH_R = 19'b1001100_00_10_001_00_000;
  localparam logic [18:0] E_DECODE  = 19'b0000000_10_01_001_00_000;
  localparam logic [18:0] E_EXR     = 19'b0000000_01_00_000_00_000;
  localparam logic [18:0] E_EXI     = 19'b0000000_01_01_001_00_000;
  localparam logic [18:0] E_EXU     = 19'b0000000_00_01_010_00_000;
  localparam logic [18:0] E_ALUWB   = 19'b0000000_00_00_001_00_110;
  localparam logic [18:0] E_MADDR_L = 19'b0000000_01_01_001_00_000;
  localparam logic [18:0] E_MADDR_S = 19'b0000000_01_01_011_00_000;
  localparam logic [18:0] E_MRD     = 19'b1010000_00_00_001_00_000;
  localparam logic [18:0] E_MWB     = 19'b0000000_00_00_001_01_110;
  localparam logic [18:0] E_MWR_W   = 19'b0110000_00_00_001_00_000;
  localparam logic [18:0] E_MWR_R   = 19'b0110000_00_00_001_00_010;
  localparam logic [18:0] E_BR      = 19'b0000011_01_00_100_00_010;
  localparam logic [18:0] E_JAL     = 19'b0000101_00_00_101_10_110;
  localparam logic [18:0] E_JALR    = 19'b0000100_01_01_001_10_110;
  localparam logic [18:0] E_TRAP    = 19'b0000000_00_00_001_00_001;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-low-phase, advance to next negedge
  task automatic cyc(input string tag, input logic [6:0] op, input logic rdy,
                     input logic [18:0] exp);
    bus.OP_i        = op;
    bus.Mem_Ready_i = rdy;
    #1;
    chk(tag, outs, exp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    bus.Mem_Ready_i = 1'b1;
    bus.OP_i        = 7'h00;
    @(negedge clk);
    #1;
    chk("rst_no_irw", outs, E_FETCH_W);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    cyc("add_f",  7'h33, 1'b1, E_FETCH_R);
    cyc("add_d",  7'h33, 1'b1, E_DECODE);
    cyc("add_ex", 7'h33, 1'b1, E_EXR);
    cyc("add_wb", 7'h33, 1'b1, E_ALUWB);

    cyc("lw_f",   7'h03, 1'b1, E_FETCH_R);
    cyc("lw_d",   7'h03, 1'b1, E_DECODE);
    cyc("lw_ma",  7'h03, 1'b1, E_MADDR_L);
    cyc("lw_rd0", 7'h03, 1'b0, E_MRD);
    cyc("lw_rd1", 7'h03, 1'b0, E_MRD);
    cyc("lw_rd2", 7'h03, 1'b0, E_MRD);
    cyc("lw_rd3", 7'h03, 1'b1, E_MRD);
    cyc("lw_wb",  7'h03, 1'b1, E_MWB);

    cyc("sw_f",   7'h23, 1'b1, E_FETCH_R);
    cyc("sw_d",   7'h23, 1'b1, E_DECODE);
    cyc("sw_ma",  7'h23, 1'b1, E_MADDR_S);
    cyc("sw_wr",  7'h23, 1'b1, E_MWR_R);

    cyc("sw2_f",  7'h23, 1'b1, E_FETCH_R);
    cyc("sw2_d",  7'h23, 1'b1, E_DECODE);
    cyc("sw2_ma", 7'h23, 1'b1, E_MADDR_S);
    cyc("sw2_w0", 7'h23, 1'b0, E_MWR_W);
    cyc("sw2_w1", 7'h23, 1'b1, E_MWR_R);

    cyc("addi_f",  7'h13, 1'b1, E_FETCH_R);
    cyc("addi_d",  7'h13, 1'b1, E_DECODE);
    cyc("addi_ex", 7'h13, 1'b1, E_EXI);
    cyc("addi_wb", 7'h13, 1'b1, E_ALUWB);

    cyc("jal_f",  7'h6F, 1'b1, E_FETCH_R);
    cyc("jal_d",  7'h6F, 1'b1, E_DECODE);
    cyc("jal_x",  7'h6F, 1'b1, E_JAL);
    cyc("beq_f",  7'h63, 1'b1, E_FETCH_R);
    cyc("beq_d",  7'h63, 1'b1, E_DECODE);
    cyc("beq_x",  7'h63, 1'b1, E_BR);
    cyc("jalr_f", 7'h67, 1'b1, E_FETCH_R);
    cyc("jalr_d", 7'h67, 1'b1, E_DECODE);
    cyc("jalr_x", 7'h67, 1'b1, E_JALR);
    cyc("lui_f",  7'h37, 1'b1, E_FETCH_R);
    cyc("lui_d",  7'h37, 1'b1, E_DECODE);
    cyc("lui_ex", 7'h37, 1'b1, E_EXU);
    cyc("lui_wb", 7'h37, 1'b1, E_ALUWB);

    // Ready in the limit cycle wins over the timeout
    cyc("fw_0",  7'h33, 1'b0, E_FETCH_W);
    cyc("fw_1",  7'h33, 1'b0, E_FETCH_W);
    cyc("fw_2",  7'h33, 1'b0, E_FETCH_W);
    cyc("fw_3r", 7'h33, 1'b1, E_FETCH_R);
    cyc("fw_d",  7'h33, 1'b1, E_DECODE);
    cyc("fw_ex", 7'h33, 1'b1, E_EXR);
    cyc("fw_wb", 7'h33, 1'b1, E_ALUWB);

    // Reset in the middle of a load
    cyc("rl_f",  7'h03, 1'b1, E_FETCH_R);
    cyc("rl_d",  7'h03, 1'b1, E_DECODE);
    cyc("rl_ma", 7'h03, 1'b1, E_MADDR_L);
    cyc("rl_rd", 7'h03, 1'b0, E_MRD);
    reset = 1'b0;
    bus.Mem_Ready_i = 1'b0;
    #1;
    chk("rl_rst", outs, E_MRD);
    @(negedge clk);
    reset = 1'b1;
    cyc("rl_fetch", 7'h03, 1'b0, E_FETCH_W);
    cyc("rl_f2",    7'h13, 1'b1, E_FETCH_R);
    cyc("rl_d2",    7'h13, 1'b1, E_DECODE);
    cyc("rl_ex2",   7'h13, 1'b1, E_EXI);
    cyc("rl_wb2",   7'h13, 1'b1, E_ALUWB);

    // Illegal opcode
    cyc("il_f",  7'h7F, 1'b1, E_FETCH_R);
    cyc("il_d",  7'h7F, 1'b1, E_DECODE);
    cyc("il_t0", 7'h7F, 1'b1, E_TRAP);
    cyc("il_t1", 7'h33, 1'b1, E_TRAP);

    do_reset();
    cyc("to_0",  7'h33, 1'b0, E_FETCH_W);
    cyc("to_1",  7'h33, 1'b0, E_FETCH_W);
    cyc("to_2",  7'h33, 1'b0, E_FETCH_W);
    cyc("to_3",  7'h33, 1'b0, E_FETCH_W);
    cyc("to_t0", 7'h33, 1'b1, E_TRAP);
    cyc("to_t1", 7'h33, 1'b1, E_TRAP);

    // Timeout during a data read
    do_reset();
    cyc("rt_f",  7'h03, 1'b1, E_FETCH_R);
    cyc("rt_d",  7'h03, 1'b1, E_DECODE);
    cyc("rt_ma", 7'h03, 1'b1, E_MADDR_L);
    cyc("rt_0",  7'h03, 1'b0, E_MRD);
    cyc("rt_1",  7'h03, 1'b0, E_MRD);
    cyc("rt_2",  7'h03, 1'b0, E_MRD);
    cyc("rt_3",  7'h03, 1'b0, E_MRD);
    cyc("rt_t",  7'h03, 1'b1, E_TRAP);

    do_reset();
    cyc("post_f", 7'h33, 1'b1, E_FETCH_R);
    cyc("post_d", 7'h33, 1'b1, E_DECODE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
